// File: rtl/trdb_pkg.sv
// Shared types and constants for the trdb trace-control blocks.
package trdb_pkg;

  localparam int unsigned RESYNC_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    ARMED    = 2'd1,
    ACTIVE   = 2'd2,
    STOPPING = 2'd3
  } sync_state_e;

  typedef enum logic {
    RESYNC_CYCLES  = 1'b0,
    RESYNC_PACKETS = 1'b1
  } resync_mode_e;

endpackage

// File: rtl/trdb_resync_counter.sv
// Saturating resync counter with synchronous clear and threshold compare.
module trdb_resync_counter
  import trdb_pkg::*;
#(
  parameter int unsigned W = RESYNC_W_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] max_i,
  output logic         gt_o,
  output logic         et_o
);

  logic [W-1:0] count_d, count_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign gt_o = (count_q >  max_i);
  assign et_o = (count_q == max_i);

endmodule

// File: rtl/trdb_sync_scheduler.sv
// Encoder lifecycle FSM and resync scheduling feeding the tc_* inputs of trdb_priority.
module trdb_sync_scheduler
  import trdb_pkg::*;
#(
  parameter int unsigned RESYNC_W = RESYNC_W_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                trace_enable_i,
  input  logic                valid_i,
  input  logic                qualified_i,
  input  logic                packet_emitted_i,
  input  logic                resync_timer_rst_i,
  input  logic                resync_mode_i,
  input  logic [RESYNC_W-1:0] max_resync_i,
  output logic                enc_enabled_o,
  output logic                enc_disabled_o,
  output logic                first_qualified_o,
  output logic                gt_max_resync_o,
  output logic                et_max_resync_o,
  output logic                active_o,
  output logic [1:0]          state_o
);

  sync_state_e state_d, state_q;
  logic        enc_enabled_d, enc_enabled_q;
  logic        enc_disabled_d, enc_disabled_q;
  logic        first_qualified_d, first_qualified_q;
  logic        enter_active;
  logic        cnt_clr, cnt_inc, cnt_gt, cnt_et;
  logic        in_active;

  always_comb begin
    state_d           = state_q;
    enc_enabled_d     = 1'b0;
    enc_disabled_d    = 1'b0;
    first_qualified_d = 1'b0;
    enter_active      = 1'b0;
    unique case (state_q)
      OFF: begin
        if (trace_enable_i) begin
          state_d       = ARMED;
          enc_enabled_d = 1'b1;
        end
      end
      ARMED: begin
        // Disable outranks a same-cycle first qualified instruction.
        if (!trace_enable_i) begin
          state_d = OFF;
        end else if (valid_i && qualified_i) begin
          state_d           = ACTIVE;
          first_qualified_d = 1'b1;
          enter_active      = 1'b1;
        end
      end
      ACTIVE: begin
        if (!trace_enable_i) begin
          state_d        = STOPPING;
          enc_disabled_d = 1'b1;
        end
      end
      STOPPING: begin
        if (packet_emitted_i) state_d = OFF;
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= OFF;
      enc_enabled_q     <= 1'b0;
      enc_disabled_q    <= 1'b0;
      first_qualified_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      enc_enabled_q     <= enc_enabled_d;
      enc_disabled_q    <= enc_disabled_d;
      first_qualified_q <= first_qualified_d;
    end
  end

  // The counter only moves while ACTIVE, which keeps it frozen through STOPPING.
  assign in_active = (state_q == ACTIVE);
  assign cnt_clr   = enter_active || (in_active && resync_timer_rst_i);
  assign cnt_inc   = in_active &&
                     ((resync_mode_e'(resync_mode_i) == RESYNC_CYCLES) || packet_emitted_i);

  trdb_resync_counter #(
    .W (RESYNC_W)
  ) u_resync_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .max_i  (max_resync_i),
    .gt_o   (cnt_gt),
    .et_o   (cnt_et)
  );

  assign enc_enabled_o     = enc_enabled_q;
  assign enc_disabled_o    = enc_disabled_q;
  assign first_qualified_o = first_qualified_q;
  assign gt_max_resync_o   = cnt_gt && in_active;
  assign et_max_resync_o   = cnt_et && in_active;
  assign active_o          = (state_q == ACTIVE) || (state_q == STOPPING);
  assign state_o           = state_q;

endmodule

// File: tb/tb_trdb_sync_scheduler.sv
// Directed table-driven bench for trdb_sync_scheduler (4-bit resync counter).
module tb_trdb_sync_scheduler;

  localparam int unsigned W = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         trace_enable_i, valid_i, qualified_i, packet_emitted_i;
  logic         resync_timer_rst_i, resync_mode_i;
  logic [W-1:0] max_resync_i;
  logic         enc_enabled_o, enc_disabled_o, first_qualified_o;
  logic         gt_max_resync_o, et_max_resync_o, active_o;
  logic [1:0]   state_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         te, v, q, pk, tr, md;
    logic [W-1:0] max;
    logic [7:0]   exp;  // {en, dis, fq, gt, et, act, state[1:0]}
  } vec_t;

  vec_t vecs[$];

  trdb_sync_scheduler #(.RESYNC_W(W)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .trace_enable_i     (trace_enable_i),
    .valid_i            (valid_i),
    .qualified_i        (qualified_i),
    .packet_emitted_i   (packet_emitted_i),
    .resync_timer_rst_i (resync_timer_rst_i),
    .resync_mode_i      (resync_mode_i),
    .max_resync_i       (max_resync_i),
    .enc_enabled_o      (enc_enabled_o),
    .enc_disabled_o     (enc_disabled_o),
    .first_qualified_o  (first_qualified_o),
    .gt_max_resync_o    (gt_max_resync_o),
    .et_max_resync_o    (et_max_resync_o),
    .active_o           (active_o),
    .state_o            (state_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] outs();
    return {enc_enabled_o, enc_disabled_o, first_qualified_o,
            gt_max_resync_o, et_max_resync_o, active_o, state_o};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (en dis fq gt et act st)", name, act, exp);
    end
  endtask

  task automatic drive(input logic te, v, q, pk, tr, md, input logic [W-1:0] max);
    trace_enable_i     = te;
    valid_i            = v;
    qualified_i        = q;
    packet_emitted_i   = pk;
    resync_timer_rst_i = tr;
    resync_mode_i      = md;
    max_resync_i       = max;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic add(input logic te, v, q, pk, tr, md, input logic [W-1:0] max,
                     input logic en, dis, fq, gt, et, act, input logic [1:0] st);
    vec_t x;
    x.te = te; x.v = v; x.q = q; x.pk = pk; x.tr = tr; x.md = md; x.max = max;
    x.exp = {en, dis, fq, gt, et, act, st};
    vecs.push_back(x);
  endtask

  initial begin
    //  te v q pk tr md max | en dis fq gt et act st
    add(0, 0, 0, 0, 0, 0, 4,  0, 0, 0, 0, 0, 0, 0);  // idle in OFF
    add(1, 0, 0, 0, 0, 0, 4,  1, 0, 0, 0, 0, 0, 1);  // enable -> ARMED
    add(1, 0, 0, 0, 0, 0, 4,  0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 4,  0, 0, 0, 0, 0, 0, 1);  // unqualified retire
    add(1, 1, 1, 0, 0, 0, 4,  0, 0, 1, 0, 0, 1, 2);  // first qualified, count 0
    add(1, 0, 0, 0, 0, 0, 4,  0, 0, 0, 0, 0, 1, 2);  // count 1
    add(1, 0, 0, 0, 0, 0, 4,  0, 0, 0, 0, 0, 1, 2);  // 2
    add(1, 0, 0, 0, 0, 0, 4,  0, 0, 0, 0, 0, 1, 2);  // 3
    add(1, 0, 0, 0, 0, 0, 4,  0, 0, 0, 0, 1, 1, 2);  // 4 == max
    add(1, 0, 0, 0, 0, 0, 4,  0, 0, 0, 1, 0, 1, 2);  // 5 > max
    add(1, 0, 0, 0, 1, 0, 4,  0, 0, 0, 0, 0, 1, 2);  // timer reset -> 0
    add(1, 0, 0, 0, 0, 0, 4,  0, 0, 0, 0, 0, 1, 2);  // 1
    add(1, 0, 0, 0, 0, 0, 4,  0, 0, 0, 0, 0, 1, 2);  // 2
    add(1, 0, 0, 0, 0, 0, 4,  0, 0, 0, 0, 0, 1, 2);  // 3
    add(1, 0, 0, 0, 0, 0, 4,  0, 0, 0, 0, 1, 1, 2);  // 4 == max again
    add(1, 0, 0, 0, 1, 1, 2,  0, 0, 0, 0, 0, 1, 2);  // packet mode, clear
    add(1, 0, 0, 1, 0, 1, 2,  0, 0, 0, 0, 0, 1, 2);  // pkt -> 1
    add(1, 0, 0, 0, 0, 1, 2,  0, 0, 0, 0, 0, 1, 2);  // idle holds 1
    add(1, 0, 0, 0, 0, 1, 2,  0, 0, 0, 0, 0, 1, 2);
    add(1, 0, 0, 1, 0, 1, 2,  0, 0, 0, 0, 1, 1, 2);  // pkt -> 2 == max
    add(1, 0, 0, 0, 0, 1, 2,  0, 0, 0, 0, 1, 1, 2);
    add(1, 0, 0, 1, 0, 1, 2,  0, 0, 0, 1, 0, 1, 2);  // pkt -> 3 > max
    add(1, 0, 0, 0, 0, 1, 2,  0, 0, 0, 1, 0, 1, 2);
    add(1, 0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 1, 1, 2);  // clear beats increment
    add(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 3);  // disable -> STOPPING
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 3);  // flags held 0
    add(1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 3);  // re-enable ignored
    add(1, 0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);  // packet -> OFF
    add(1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 1);  // re-arm
    add(0, 1, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);  // disable beats qualify
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1);
    add(1, 1, 1, 0, 0, 0, 0,  0, 0, 1, 0, 1, 1, 2);  // max 0: et on first cycle

    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0, '0);
    step();
    step();
    check("reset_state", outs(), 8'b0000_0000);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].te, vecs[i].v, vecs[i].q, vecs[i].pk, vecs[i].tr, vecs[i].md, vecs[i].max);
      step();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Saturation: clear, then 20 cycle-mode increments against max 15.
    drive(1, 0, 0, 0, 1, 0, 4'd15);
    step();
    check("sat_clear", outs(), 8'b0000_0110);
    resync_timer_rst_i = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) check("sat_14", outs(), 8'b0000_0110);
      if (i == 15) check("sat_15", outs(), 8'b0000_1110);
      if (i == 20) check("sat_20", outs(), 8'b0000_1110);
    end

    // Asynchronous reset mid-cycle, held across an edge, then clean exit.
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_reset", outs(), 8'b0000_0000);
    step();
    check("reset_held", outs(), 8'b0000_0000);
    trace_enable_i = 1'b0;
    #2;
    rst_ni = 1'b1;
    step();
    check("reset_exit_1", outs(), 8'b0000_0000);
    step();
    check("reset_exit_2", outs(), 8'b0000_0000);
    trace_enable_i = 1'b1;
    step();
    check("rearm_after_reset", outs(), 8'b1000_0001);
    step();
    check("enable_pulse_once", outs(), 8'b0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
